csr_trap_unit: RTL and testbench
================================

CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 Parameter WIDTH, default 32, data/address width of all CSR and PC values.
REQ-002 Parameter VECTORED_EN, default 1; 1 enables mtvec vectored mode, 0 forces direct mode.
REQ-003 Parameter MCYCLE_EN, default 1; 1 implements 64-bit mcycle/mcycleh, 0 makes them read 0.
REQ-004 Port clk input 1: single clock, rising edge.
REQ-005 Port rst_n input 1: asynchronous, active-low reset.
REQ-006 Port csr_addr_i input 12: CSR address.
REQ-007 Port csr_wdata input WIDTH: operand (rs1 value).
REQ-008 Port csr_op input 2: 00 none, 01 write, 10 set, 11 clear.
REQ-009 Port csr_reg_rd input 1: read enable.
REQ-010 Port csr_pc input WIDTH: PC of the current instruction, saved on trap.
REQ-011 Port is_mret input 1: MRET in the current cycle.
REQ-012 Ports irq_ext, irq_timer, irq_sw input 1 each: level interrupt requests.
REQ-013 Port csr_rdata output WIDTH: read data.
REQ-014 Port interrupt_sel output 1: trap_req OR is_mret, combinational.
REQ-015 Port epc_taken output 1: registered redirect pulse.
REQ-016 Port csr_epc output WIDTH: registered redirect target.

Function
REQ-017 Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80.
REQ-018 Reads are combinational, return the pre-update value, and give 0 when csr_reg_rd=0 or the address is unmapped.
REQ-019 Write-op arithmetic: write gives new=wdata, set gives new=old|wdata, clear gives new=old&~wdata, all at the rising edge.
REQ-020 Write masks:
- mstatus keeps only bits 3 (MIE) and 7 (MPIE); MPP[12:11] reads 2'b11.
- mie keeps bits 3, 7 and 11.
- mepc bit 0 is forced to 0.
- mtvec bit 1 reads 0, and bit 0 reads 0 when VECTORED_EN=0.
- mip and mcause are read-only to csr_op; writes are ignored.
REQ-021 mip is registered every cycle: bit 11 = irq_ext, bit 7 = irq_timer, bit 3 = irq_sw; all other bits are 0.
REQ-022 pend = mip & mie; trap_req = mstatus.MIE & (pend != 0), combinational.
REQ-023 Interrupt priority is external (cause 11) > software (3) > timer (7).
REQ-024 On a trap_req cycle, at the next edge:
- mepc <= csr_pc (bit 0 cleared).
- mcause <= {1'b1, cause}.
- MPIE <= MIE and MIE <= 0.
- epc_taken <= 1.
- csr_epc <= base in direct mode, or base + 4*cause in vectored mode.
- base = {mtvec[WIDTH-1:2], 2'b00}.
REQ-025 On is_mret without trap_req, at the next edge: MIE <= MPIE, MPIE <= 1, epc_taken <= 1, csr_epc <= mepc.
REQ-026 When neither trap_req nor is_mret is active, epc_taken <= 0 and csr_epc <= 0, so epc_taken is a single-cycle pulse per event.
REQ-027 Simultaneous trap_req and is_mret: the trap wins and the MRET is ignored.
REQ-028 Simultaneous trap_req and a csr_op to mstatus, mepc or mcause: the trap update wins; csr_op writes to any other CSR still complete.
REQ-029 Simultaneous is_mret and a csr_op to mstatus: the MRET update wins.
REQ-030 Because MIE clears on trap entry, trap_req deasserts the cycle after entry, so no back-to-back re-entry is possible.
REQ-031 mcycle (64-bit) increments by 1 every cycle and wraps from 2^64-1 to 0.
REQ-032 A csr_op to mcycle (0xB00) or mcycleh (0xB80) replaces the addressed 32-bit half with the op result and suppresses the increment for that cycle.
REQ-033 Latency: a CSR write is visible on read the next cycle; the redirect appears 1 cycle after trap_req or is_mret.

Reset
REQ-034 While rst_n=0, asynchronously clear all CSRs, mcycle, epc_taken and csr_epc to 0.
REQ-035 After reset: mstatus reads 0x1800, csr_rdata is 0, and interrupt_sel is 0 unless is_mret=1.
REQ-036 Reset asserted mid-trap cancels any pending epc_taken; on release the block starts from the reset state.

Verification
REQ-037 Vectored external interrupt:
- Stimulus: write mtvec=0x0000_1001, mie=0x800, mstatus=0x8; csr_pc=0x200; raise irq_ext.
- Response: mip updates one cycle later; trap_req is then asserted; the next cycle gives epc_taken=1, csr_epc=0x102C.
- Resulting CSRs: mepc=0x200, mcause=0x8000_000B, mstatus=0x1880.
REQ-038 Priority:
- Stimulus: all three irqs with all enables set and direct mode, mtvec=0x400.
- Response: mcause=0x8000_000B, csr_epc=0x400.
- Then: after MRET with only irq_sw and irq_timer still asserted, mcause=0x8000_0003.
REQ-039 MRET:
- Stimulus: with mepc=0x200 and mstatus=0x1880, pulse is_mret.
- Response: epc_taken=1, csr_epc=0x200, mstatus=0x1888.
REQ-040 Set/clear:
- Stimulus: mie=0x008, then set 0x880, then clear 0x008.
- Response: mie reads 0x888, then 0x880; a write of 0xFFFF_FFFF to mie reads back 0x888.
REQ-041 mcycle:
- Stimulus: write mcycle=0xFFFF_FFFF and mcycleh=0x0.
- Response: 2 cycles later mcycleh=1 and mcycle=0x0000_0001.
REQ-042 Conflict and reset:
- Stimulus: trap_req together with a write of 0 to mepc.
- Response: mepc=csr_pc.
- Then: assert rst_n=0 in the epc_taken cycle; epc_taken drops immediately.

Source files
------------

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with prioritised interrupt entry,
// MRET return and a 64-bit cycle counter.
module csr_trap_unit #(
    parameter int WIDTH       = 32,
    parameter bit VECTORED_EN = 1'b1,
    parameter bit MCYCLE_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      csr_addr_i,
    input  logic [WIDTH-1:0] csr_wdata,
    input  logic [1:0]       csr_op,
    input  logic             csr_reg_rd,
    input  logic [WIDTH-1:0] csr_pc,
    input  logic             is_mret,
    input  logic             irq_ext,
    input  logic             irq_timer,
    input  logic             irq_sw,
    output logic [WIDTH-1:0] csr_rdata,
    output logic             interrupt_sel,
    output logic             epc_taken,
    output logic [WIDTH-1:0] csr_epc
);
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

    logic             st_mie, st_mpie;
    logic [2:0]       ie, ip;  // {external, timer, software}
    logic [WIDTH-1:0] mtvec, mepc, mcause;
    logic [63:0]      mcycle;
    logic [WIDTH-1:0] mstatus_val, mie_val, mip_val, cur, op_res, base, target;
    logic [2:0]       pend;
    logic [3:0]       cause;
    logic             trap_req, wr;

    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = st_mpie;
        mstatus_val[3]     = st_mie;
        mie_val            = '0;
        mie_val[11]        = ie[2];
        mie_val[7]         = ie[1];
        mie_val[3]         = ie[0];
        mip_val            = '0;
        mip_val[11]        = ip[2];
        mip_val[7]         = ip[1];
        mip_val[3]         = ip[0];
    end

    always_comb begin
        case (csr_addr_i)
            ADDR_MSTATUS: cur = mstatus_val;
            ADDR_MIE:     cur = mie_val;
            ADDR_MTVEC:   cur = mtvec;
            ADDR_MEPC:    cur = mepc;
            ADDR_MCAUSE:  cur = mcause;
            ADDR_MIP:     cur = mip_val;
            ADDR_MCYCLE:  cur = MCYCLE_EN ? WIDTH'(mcycle[31:0]) : '0;
            ADDR_MCYCLEH: cur = MCYCLE_EN ? WIDTH'(mcycle[63:32]) : '0;
            default:      cur = '0;
        endcase
    end

    assign csr_rdata     = csr_reg_rd ? cur : '0;
    assign wr            = |csr_op;
    assign op_res        = (csr_op == 2'b01) ? csr_wdata :
                           (csr_op == 2'b10) ? (cur | csr_wdata) : (cur & ~csr_wdata);
    assign pend          = ip & ie;
    assign trap_req      = st_mie & |pend;
    // External beats software beats timer.
    assign cause         = pend[2] ? 4'd11 : pend[0] ? 4'd3 : 4'd7;
    assign base          = {mtvec[WIDTH-1:2], 2'b00};
    assign target        = (VECTORED_EN && mtvec[0]) ? base + (WIDTH'(cause) << 2) : base;
    assign interrupt_sel = trap_req | is_mret;

    // Trap and MRET updates are placed after the csr_op writes so they take priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie    <= 1'b0;
            st_mpie   <= 1'b0;
            ie        <= '0;
            ip        <= '0;
            mtvec     <= '0;
            mepc      <= '0;
            mcause    <= '0;
            epc_taken <= 1'b0;
            csr_epc   <= '0;
        end else begin
            ip <= {irq_ext, irq_timer, irq_sw};
            if (wr && csr_addr_i == ADDR_MSTATUS) begin
                st_mie  <= op_res[3];
                st_mpie <= op_res[7];
            end
            if (wr && csr_addr_i == ADDR_MIE)
                ie <= {op_res[11], op_res[7], op_res[3]};
            if (wr && csr_addr_i == ADDR_MTVEC)
                mtvec <= {op_res[WIDTH-1:2], 1'b0, op_res[0] & VECTORED_EN};
            if (wr && csr_addr_i == ADDR_MEPC)
                mepc <= {op_res[WIDTH-1:1], 1'b0};
            if (trap_req) begin
                mepc      <= {csr_pc[WIDTH-1:1], 1'b0};
                mcause    <= {1'b1, {(WIDTH-5){1'b0}}, cause};
                st_mpie   <= st_mie;
                st_mie    <= 1'b0;
                epc_taken <= 1'b1;
                csr_epc   <= target;
            end else if (is_mret) begin
                st_mie    <= st_mpie;
                st_mpie   <= 1'b1;
                epc_taken <= 1'b1;
                csr_epc   <= mepc;
            end else begin
                epc_taken <= 1'b0;
                csr_epc   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mcycle <= '0;
        else if (!MCYCLE_EN)
            mcycle <= '0;
        else if (wr && csr_addr_i == ADDR_MCYCLE)
            mcycle[31:0] <= op_res[31:0];
        else if (wr && csr_addr_i == ADDR_MCYCLEH)
            mcycle[63:32] <= op_res[31:0];
        else
            mcycle <= mcycle + 64'd1;
    end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed and randomized checks of csr_trap_unit against
// a value-level model of the machine CSRs.
module tb_csr_trap_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata, csr_pc, csr_rdata, csr_epc;
    logic [1:0]  csr_op;
    logic        csr_reg_rd, is_mret, irq_ext, irq_timer, irq_sw;
    logic        interrupt_sel, epc_taken;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip, m_epc;
    logic [63:0] m_cyc;
    logic        m_taken;
    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                12'h344, 12'hB00, 12'hB80, 12'h7C0, 12'h300};

    csr_trap_unit dut (
        .clk(clk), .rst_n(rst_n), .csr_addr_i(csr_addr_i), .csr_wdata(csr_wdata),
        .csr_op(csr_op), .csr_reg_rd(csr_reg_rd), .csr_pc(csr_pc), .is_mret(is_mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw), .csr_rdata(csr_rdata),
        .interrupt_sel(interrupt_sel), .epc_taken(epc_taken), .csr_epc(csr_epc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_val(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_trap();
        return m_mstatus[3] && ((m_mip & m_mie) != 32'h0);
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] p;
        p = m_mip & m_mie;
        return p[11] ? 32'd11 : p[3] ? 32'd3 : 32'd7;
    endfunction

    task automatic m_reset();
        m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_mip = 0; m_cyc = 0; m_taken = 0; m_epc = 0;
    endtask

    task automatic drive(input logic [11:0] a, input logic [31:0] w, input logic [1:0] op,
                         input logic rd, input logic mret);
        @(negedge clk);
        csr_addr_i = a; csr_wdata = w; csr_op = op; csr_reg_rd = rd; is_mret = mret;
        #1;
    endtask

    // Advances one clock edge, computing the model's next state from the driven inputs.
    task automatic tick();
        logic [31:0] old, res, ns, nie, ntv, nep, nca, nip, base, nepc;
        logic [63:0] ncyc;
        logic        ntk;
        old = m_val(csr_addr_i);
        res = (csr_op == 2'd1) ? csr_wdata : (csr_op == 2'd2) ? (old | csr_wdata) : (old & ~csr_wdata);
        ns = m_mstatus; nie = m_mie; ntv = m_mtvec; nep = m_mepc; nca = m_mcause;
        ncyc = m_cyc + 64'd1;
        if (csr_op != 2'd0) begin
            case (csr_addr_i)
                12'h300: ns = 32'h1800 | (res & 32'h88);
                12'h304: nie = res & 32'h888;
                12'h305: ntv = res & 32'hFFFF_FFFD;
                12'h341: nep = res & 32'hFFFF_FFFE;
                12'hB00: ncyc = {m_cyc[63:32], res};
                12'hB80: ncyc = {res, m_cyc[31:0]};
                default: ;
            endcase
        end
        base = m_mtvec & 32'hFFFF_FFFC;
        if (m_trap()) begin
            nep = csr_pc & 32'hFFFF_FFFE; nca = 32'h8000_0000 | m_cause(); ns = 32'h1880;
            ntk = 1; nepc = m_mtvec[0] ? base + 4 * m_cause() : base;
        end else if (is_mret) begin
            ns = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0); ntk = 1; nepc = m_mepc;
        end else begin
            ntk = 0; nepc = 0;
        end
        nip = (irq_ext ? 32'h800 : 0) | (irq_timer ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0);
        @(posedge clk);
        #1;
        m_mstatus = ns; m_mie = nie; m_mtvec = ntv; m_mepc = nep; m_mcause = nca;
        m_mip = nip; m_cyc = ncyc; m_taken = ntk; m_epc = nepc;
    endtask

    task automatic test_reset();
        rst_n = 0; csr_addr_i = 0; csr_wdata = 0; csr_op = 0; csr_reg_rd = 0; csr_pc = 0;
        is_mret = 0; irq_ext = 0; irq_timer = 0; irq_sw = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (epc_taken !== 1'b0) begin n_err++; $display("FAIL rst_epc_taken: got %b exp 0", epc_taken); end
        n_chk++; if (csr_epc !== 32'h0) begin n_err++; $display("FAIL rst_csr_epc: got %h exp 0", csr_epc); end
        rst_n = 1;
        drive(12'h300, 0, 0, 0, 0);
        n_chk++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata_gated: got %h exp 0", csr_rdata); end
        n_chk++; if (interrupt_sel !== 1'b0) begin n_err++; $display("FAIL rst_isel: got %b exp 0", interrupt_sel); end
        tick();
        drive(12'h300, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h1800) begin n_err++; $display("FAIL rst_mstatus: got %h exp 1800", csr_rdata); end
        tick();
        drive(12'h300, 0, 0, 0, 1);
        n_chk++; if (interrupt_sel !== 1'b1) begin n_err++; $display("FAIL rst_isel_mret: got %b exp 1", interrupt_sel); end
        tick();
        n_chk++; if (epc_taken !== 1'b1) begin n_err++; $display("FAIL rst_mret_taken: got %b exp 1", epc_taken); end
    endtask

    task automatic test_vectored_ext();
        csr_pc = 32'h200;
        drive(12'h305, 32'h1001, 1, 0, 0); tick();
        drive(12'h304, 32'h800, 1, 0, 0); tick();
        drive(12'h300, 32'h8, 1, 0, 0); tick();
        irq_ext = 1;
        drive(12'h0, 0, 0, 0, 0);
        n_chk++; if (interrupt_sel !== 1'b0) begin n_err++; $display("FAIL vec_isel_before_mip: got %b exp 0", interrupt_sel); end
        tick();
        drive(12'h0, 0, 0, 0, 0);
        n_chk++; if (interrupt_sel !== 1'b1) begin n_err++; $display("FAIL vec_isel: got %b exp 1", interrupt_sel); end
        tick();
        n_chk++; if (epc_taken !== 1'b1) begin n_err++; $display("FAIL vec_taken: got %b exp 1", epc_taken); end
        n_chk++; if (csr_epc !== 32'h102C) begin n_err++; $display("FAIL vec_epc: got %h exp 102c", csr_epc); end
        drive(12'h341, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h200) begin n_err++; $display("FAIL vec_mepc: got %h exp 200", csr_rdata); end
        n_chk++; if (interrupt_sel !== 1'b0) begin n_err++; $display("FAIL vec_no_reentry: got %b exp 0", interrupt_sel); end
        tick();
        n_chk++; if (epc_taken !== 1'b0) begin n_err++; $display("FAIL vec_pulse_end: got %b exp 0", epc_taken); end
        drive(12'h342, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h8000_000B) begin n_err++; $display("FAIL vec_mcause: got %h exp 8000000b", csr_rdata); end
        tick();
        drive(12'h300, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h1880) begin n_err++; $display("FAIL vec_mstatus: got %h exp 1880", csr_rdata); end
        tick();
        irq_ext = 0;
    endtask

    task automatic test_mret();
        drive(12'h300, 0, 0, 1, 1);
        n_chk++; if (interrupt_sel !== 1'b1) begin n_err++; $display("FAIL mret_isel: got %b exp 1", interrupt_sel); end
        tick();
        n_chk++; if (epc_taken !== 1'b1) begin n_err++; $display("FAIL mret_taken: got %b exp 1", epc_taken); end
        n_chk++; if (csr_epc !== 32'h200) begin n_err++; $display("FAIL mret_epc: got %h exp 200", csr_epc); end
        drive(12'h300, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus: got %h exp 1888", csr_rdata); end
        tick();
        n_chk++; if (epc_taken !== 1'b0) begin n_err++; $display("FAIL mret_pulse_end: got %b exp 0", epc_taken); end
    endtask

    task automatic test_priority();
        drive(12'h305, 32'h400, 1, 0, 0); tick();
        drive(12'h304, 32'h888, 1, 0, 0); tick();
        drive(12'h300, 32'h8, 1, 0, 0); tick();
        irq_ext = 1; irq_timer = 1; irq_sw = 1;
        drive(12'h0, 0, 0, 0, 0); tick();
        drive(12'h0, 0, 0, 0, 0); tick();
        n_chk++; if (csr_epc !== 32'h400) begin n_err++; $display("FAIL prio_epc_direct: got %h exp 400", csr_epc); end
        drive(12'h342, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h8000_000B) begin n_err++; $display("FAIL prio_ext: got %h exp 8000000b", csr_rdata); end
        tick();
        irq_ext = 0;
        drive(12'h0, 0, 0, 0, 1); tick();
        drive(12'h0, 0, 0, 0, 0);
        n_chk++; if (interrupt_sel !== 1'b1) begin n_err++; $display("FAIL prio_retrap: got %b exp 1", interrupt_sel); end
        tick();
        n_chk++; if (csr_epc !== 32'h400) begin n_err++; $display("FAIL prio_epc2: got %h exp 400", csr_epc); end
        drive(12'h342, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h8000_0003) begin n_err++; $display("FAIL prio_sw_over_timer: got %h exp 80000003", csr_rdata); end
        tick();
        irq_timer = 0; irq_sw = 0;
    endtask

    task automatic test_set_clear();
        drive(12'h304, 32'h008, 1, 0, 0); tick();
        drive(12'h304, 32'h880, 2, 0, 0); tick();
        drive(12'h304, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h888) begin n_err++; $display("FAIL set_mie: got %h exp 888", csr_rdata); end
        tick();
        drive(12'h304, 32'h008, 3, 0, 0); tick();
        drive(12'h304, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h880) begin n_err++; $display("FAIL clear_mie: got %h exp 880", csr_rdata); end
        tick();
        drive(12'h304, 32'hFFFF_FFFF, 1, 0, 0); tick();
        drive(12'h304, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h888) begin n_err++; $display("FAIL mask_mie: got %h exp 888", csr_rdata); end
        tick();
        drive(12'h305, 32'hFFFF_FFFF, 1, 0, 0); tick();
        drive(12'h305, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mask_mtvec: got %h exp fffffffd", csr_rdata); end
        tick();
        drive(12'h341, 32'h123, 1, 0, 0); tick();
        drive(12'h341, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h122) begin n_err++; $display("FAIL mask_mepc: got %h exp 122", csr_rdata); end
        tick();
        drive(12'h342, 32'hFFFF_FFFF, 1, 0, 0); tick();
        drive(12'h342, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h8000_0003) begin n_err++; $display("FAIL ro_mcause: got %h exp 80000003", csr_rdata); end
        tick();
        drive(12'h344, 32'hFFFF_FFFF, 1, 0, 0); tick();
        drive(12'h344, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL ro_mip: got %h exp 0", csr_rdata); end
        tick();
        drive(12'h7C0, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h exp 0", csr_rdata); end
        tick();
    endtask

    task automatic test_mcycle();
        drive(12'hB00, 32'hFFFF_FFFF, 1, 0, 0); tick();
        drive(12'hB80, 32'h0, 1, 0, 0); tick();
        drive(12'h0, 0, 0, 0, 0); tick();
        drive(12'h0, 0, 0, 0, 0); tick();
        drive(12'hB00, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h1) begin n_err++; $display("FAIL mcycle_lo: got %h exp 1", csr_rdata); end
        tick();
        drive(12'hB80, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h1) begin n_err++; $display("FAIL mcycle_hi: got %h exp 1", csr_rdata); end
        tick();
    endtask

    task automatic test_conflict_reset();
        drive(12'h305, 32'h400, 1, 0, 0); tick();
        drive(12'h300, 32'h8, 1, 0, 0); tick();
        irq_sw = 1; csr_pc = 32'h300;
        drive(12'h0, 0, 0, 0, 0); tick();
        drive(12'h341, 32'h0, 1, 0, 0);
        n_chk++; if (interrupt_sel !== 1'b1) begin n_err++; $display("FAIL conf_isel: got %b exp 1", interrupt_sel); end
        tick();
        n_chk++; if (epc_taken !== 1'b1) begin n_err++; $display("FAIL conf_taken: got %b exp 1", epc_taken); end
        drive(12'h341, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h300) begin n_err++; $display("FAIL conf_mepc: got %h exp 300", csr_rdata); end
        rst_n = 0;
        #1;
        n_chk++; if (epc_taken !== 1'b0) begin n_err++; $display("FAIL conf_async_taken: got %b exp 0", epc_taken); end
        n_chk++; if (csr_epc !== 32'h0) begin n_err++; $display("FAIL conf_async_epc: got %h exp 0", csr_epc); end
        n_chk++; if (csr_rdata !== 32'h0) begin n_err++; $display("FAIL conf_async_mepc: got %h exp 0", csr_rdata); end
        m_reset();
        irq_sw = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        drive(12'h300, 0, 0, 1, 0);
        n_chk++; if (csr_rdata !== 32'h1800) begin n_err++; $display("FAIL conf_post_mstatus: got %h exp 1800", csr_rdata); end
        n_chk++; if (interrupt_sel !== 1'b0) begin n_err++; $display("FAIL conf_post_isel: got %b exp 0", interrupt_sel); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 600; i++) begin
            irq_ext = ($urandom_range(0, 3) == 0);
            irq_timer = ($urandom_range(0, 3) == 0);
            irq_sw = ($urandom_range(0, 3) == 0);
            csr_pc = $urandom;
            w = ($urandom_range(0, 3) == 0) ? 32'h888 : $urandom;
            drive(addrs[$urandom_range(0, 9)], w, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            n_chk++; if (csr_rdata !== (csr_reg_rd ? m_val(csr_addr_i) : 32'h0)) begin n_err++; $display("FAIL rnd_rdata[%0d]: addr %h got %h exp %h", i, csr_addr_i, csr_rdata, csr_reg_rd ? m_val(csr_addr_i) : 32'h0); end
            n_chk++; if (interrupt_sel !== (m_trap() | is_mret)) begin n_err++; $display("FAIL rnd_isel[%0d]: got %b exp %b", i, interrupt_sel, m_trap() | is_mret); end
            tick();
            n_chk++; if (epc_taken !== m_taken) begin n_err++; $display("FAIL rnd_taken[%0d]: got %b exp %b", i, epc_taken, m_taken); end
            n_chk++; if (csr_epc !== m_epc) begin n_err++; $display("FAIL rnd_epc[%0d]: got %h exp %h", i, csr_epc, m_epc); end
        end
    endtask

    initial begin
        test_reset();
        test_vectored_ext();
        test_mret();
        test_priority();
        test_set_clear();
        test_mcycle();
        test_conflict_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
